// File: rtl/mul32_pipelined.sv
// 32x32 multiplier, signed or unsigned per operand pair, 8 register stages.
// A modified Baugh-Wooley array feeds a Dadda tree, followed by a three-slice pipelined adder.
module mul32_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int COLS = 64;
  localparam int MAXH = 33;

  // Bit heap: heap[column][slot]. Each column is packed from slot 0 upward.
  typedef logic [COLS-1:0][MAXH-1:0] heap_t;

  // Heights of the partial-product heap, including the correction constant 2^33.
  function automatic int init_height(input int c);
    return ((c <= 32) ? c + 1 : 65 - c) + ((c == 33) ? 1 : 0);
  endfunction

  function automatic int level_target(input int lvl);
    case (lvl)
      0:       return 28;
      1:       return 19;
      2:       return 13;
      3:       return 9;
      4:       return 6;
      5:       return 4;
      6:       return 3;
      default: return 2;
    endcase
  endfunction

  // The operands become 33-bit signed values: mode=0 zero-extends them and mode=1 sign-extends them.
  // One signed Baugh-Wooley array therefore covers both modes. Column 65 of the constant lies outside the 64-bit product.
  function automatic heap_t gen_pp(input logic [31:0] x, input logic [31:0] y,
                                   input logic m);
    logic [32:0] xe;
    logic [32:0] ye;
    logic        pp;
    int          cnt [COLS];
    heap_t       heap;
    xe   = {m & x[31], x};
    ye   = {m & y[31], y};
    heap = '0;
    for (int c = 0; c < COLS; c++) cnt[c] = 0;
    for (int i = 0; i <= 32; i++) begin
      for (int j = 0; j <= 32; j++) begin
        if (i + j < COLS) begin
          pp = xe[j] & ye[i];
          if ((i == 32) != (j == 32)) pp = ~pp;
          heap[i+j][cnt[i+j]] = pp;
          cnt[i+j]++;
        end
      end
    end
    heap[33][cnt[33]] = 1'b1;
    return heap;
  endfunction

  // Runs Dadda levels 0..last. The heights are always traced from the initial heap.
  // The bits are only transformed for levels first..last, because heap_in already has the shape at level 'first'.
  function automatic heap_t dadda_levels(input heap_t heap_in, input int first,
                                         input int last);
    heap_t cur;
    heap_t nxt;
    int    h  [COLS];
    int    hn [COLS];
    int    tot;
    int    src;
    int    d;
    logic  x0, x1, x2;
    cur = heap_in;
    for (int c = 0; c < COLS; c++) h[c] = init_height(c);
    for (int lvl = 0; lvl <= last; lvl++) begin
      d   = level_target(lvl);
      nxt = '0;
      for (int c = 0; c < COLS; c++) hn[c] = 0;
      for (int c = 0; c < COLS; c++) begin
        tot = h[c] + hn[c];
        src = 0;
        while (tot > d && src + 2 <= h[c]) begin
          x0 = cur[c][src];
          x1 = cur[c][src+1];
          if (tot - d >= 2 && src + 3 <= h[c]) begin
            x2         = cur[c][src+2];
            nxt[c][hn[c]] = x0 ^ x1 ^ x2;
            if (c + 1 < COLS) begin
              nxt[c+1][hn[c+1]] = (x0 & x1) | (x0 & x2) | (x1 & x2);
              hn[c+1]++;
            end
            src += 3;
            tot -= 2;
          end else begin
            nxt[c][hn[c]] = x0 ^ x1;
            if (c + 1 < COLS) begin
              nxt[c+1][hn[c+1]] = x0 & x1;
              hn[c+1]++;
            end
            src += 2;
            tot -= 1;
          end
          hn[c]++;
        end
        for (int k = src; k < h[c]; k++) begin
          nxt[c][hn[c]] = cur[c][k];
          hn[c]++;
        end
      end
      h = hn;
      if (lvl >= first) cur = nxt;
    end
    return cur;
  endfunction

  // The last two levels return the two remaining rows, packed as {row_y, row_x}.
  function automatic logic [127:0] final_rows(input heap_t heap_in);
    heap_t       r;
    logic [63:0] rx;
    logic [63:0] ry;
    r = dadda_levels(heap_in, 6, 7);
    for (int c = 0; c < COLS; c++) begin
      rx[c] = r[c][0];
      ry[c] = r[c][1];
    end
    return {ry, rx};
  endfunction

  // Stage registers.
  logic [31:0]  a_q, b_q;
  logic         mode_q;
  heap_t        heap2, heap3, heap4;
  logic [63:0]  row_x, row_y;
  logic [21:0]  sum6;
  logic [42:0]  x6, y6;
  logic [21:0]  sum7;
  logic [20:0]  lo7;
  logic [21:0]  x7, y7;
  logic [63:0]  prod;

  heap_t        lvl01, lvl23, lvl45;
  logic [127:0] rows;

  assign lvl01 = dadda_levels(gen_pp(a_q, b_q, mode_q), 0, 1);
  assign lvl23 = dadda_levels(heap2, 2, 3);
  assign lvl45 = dadda_levels(heap3, 4, 5);
  assign rows  = final_rows(heap4);

  // NOTE: every pipeline register, including the wide heap registers, is cleared by reset.
  // This guarantees that no stale product ever reaches hi/lo after reset is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      heap2  <= '0;
      heap3  <= '0;
      heap4  <= '0;
      row_x  <= '0;
      row_y  <= '0;
      sum6   <= '0;
      x6     <= '0;
      y6     <= '0;
      sum7   <= '0;
      lo7    <= '0;
      x7     <= '0;
      y7     <= '0;
      prod   <= '0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
      heap2  <= lvl01;
      heap3  <= lvl23;
      heap4  <= lvl45;
      row_x  <= rows[63:0];
      row_y  <= rows[127:64];
      // Carry-propagate adder split into slices [20:0], [41:21] and [63:42].
      sum6   <= {1'b0, row_x[20:0]} + {1'b0, row_y[20:0]};
      x6     <= row_x[63:21];
      y6     <= row_y[63:21];
      sum7   <= {1'b0, x6[20:0]} + {1'b0, y6[20:0]} + {21'b0, sum6[21]};
      lo7    <= sum6[20:0];
      x7     <= x6[42:21];
      y7     <= y6[42:21];
      prod   <= {x7 + y7 + {21'b0, sum7[21]}, sum7[20:0], lo7};
    end
  end

  assign hi = prod[63:32];
  assign lo = prod[31:0];

endmodule

// File: tb/tb_mul32_pipelined.sv
// Scoreboard bench for mul32_pipelined. An expected product is queued at each capture edge.
// It is compared once eight captures are outstanding.
module tb_mul32_pipelined;

  logic        clk;
  logic        rst;
  logic [31:0] a, b;
  logic        mode;
  logic [31:0] hi, lo;

  typedef struct {
    string       tag;
    logic [63:0] prod;
  } exp_t;

  exp_t  sb [$];
  string cur_tag;
  int    n_checks;
  int    n_errors;

  mul32_pipelined dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .mode (mode),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic m);
    logic signed [63:0] sx, sy;
    if (m) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h at %0t",
               tag, got[63:32], got[31:0], exp[63:32], exp[31:0], $time);
    end
  endtask

  // Capture side: record what the DUT samples on this edge.
  always @(posedge clk) begin
    exp_t e;
    if (!rst) begin
      e.tag  = cur_tag;
      e.prod = model(a, b, mode);
      sb.push_back(e);
    end
  end

  // Output side: product of capture N is due after edge N+7, i.e. when eight captures are queued.
  always @(negedge clk) begin
    exp_t e;
    if (rst) check("reset", {hi, lo}, 64'd0);
    else if (sb.size() >= 8) begin
      e = sb.pop_front();
      check(e.tag, {hi, lo}, e.prod);
    end else check("fill", {hi, lo}, 64'd0);
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic m,
                       input string tag);
    @(posedge clk);
    #2;
    a       = x;
    b       = y;
    mode    = m;
    cur_tag = tag;
  endtask

  logic [31:0] lfsr_a, lfsr_b;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    a        = 32'h0;
    b        = 32'h0;
    mode     = 1'b0;
    cur_tag  = "idle";

    // Operands present while in reset must not leak through.
    repeat (2) drive(32'hFFFFFFFF, 32'h12345678, 1'b1, "idle");
    @(posedge clk);
    #2;
    rst = 1'b0;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; mode = 1'b0; cur_tag = "umax";

    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "s_m1_m1");
    drive(32'h80000000, 32'h80000000, 1'b1, "s_min_min");
    drive(32'hFFFFFFFF, 32'h00000001, 1'b1, "s_m1_p1");
    drive(32'h80000000, 32'h7FFFFFFF, 1'b1, "s_min_max");
    drive(32'h80000000, 32'h7FFFFFFF, 1'b0, "u_min_max");

    for (int i = 0; i < 8; i++)
      drive(32'hDEADBEEF, 32'h00000001, i[0], "mode_alt");

    // Latency: a single non-zero pair surrounded by zeros.
    repeat (3) drive(32'h0, 32'h0, 1'b0, "zero");
    drive(32'd3, 32'd5, 1'b0, "lat_3x5");
    repeat (3) drive(32'h0, 32'h0, 1'b0, "zero");

    // Operands held constant across several cycles.
    repeat (5) drive(32'hCAFEF00D, 32'h8BADF00D, 1'b1, "hold");

    lfsr_a = 32'h00000001;
    lfsr_b = 32'hDEADBEEF;
    for (int i = 0; i < 10000; i++) begin
      drive(lfsr_a, lfsr_b, 1'($urandom_range(0, 1)), "random");
      lfsr_a = lfsr_a[0] ? ((lfsr_a >> 1) ^ 32'h80200003) : (lfsr_a >> 1);
      lfsr_b = lfsr_b[0] ? ((lfsr_b >> 1) ^ 32'h80000063) : (lfsr_b >> 1);
    end

    // Asynchronous reset while the pipeline is full of non-zero products.
    repeat (8) drive(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, "pre_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", {hi, lo}, 64'd0);
    sb.delete();
    repeat (2) drive(32'h55555555, 32'hAAAAAAAA, 1'b1, "in_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    a = 32'h12345678; b = 32'h9ABCDEF0; mode = 1'b1; cur_tag = "post_rst";
    repeat (12) drive(32'h0, 32'h0, 1'b0, "drain");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
